// File: rtl/sincos_pkg.sv
// Shared types and constants for the sin/cos Horner evaluator.
// Coefficients are single-precision Taylor terms, top term first.
package sincos_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SQ,
    MUL,
    ADD,
    FIN
  } state_t;

  localparam logic [31:0] C_ONE   = 32'h3F80_0000;
  localparam logic [31:0] SIN_C3  = 32'hBE2A_AAAB;
  localparam logic [31:0] SIN_C5  = 32'h3C08_8889;
  localparam logic [31:0] SIN_C7  = 32'hB950_0D01;
  localparam logic [31:0] COS_C2  = 32'hBF00_0000;
  localparam logic [31:0] COS_C4  = 32'h3D2A_AAAB;
  localparam logic [31:0] COS_C6  = 32'hBAB6_0B61;
  localparam logic [31:0] COS_C8  = 32'h37D0_0D01;

  localparam logic [2:0] SIN_STEPS = 3'd3;
  localparam logic [2:0] COS_STEPS = 3'd4;

endpackage

// File: rtl/sincos_horner_if.sv
// Request/response bundle for the sin/cos evaluator.
// The master issues start/sel/x; the slave returns status and result.
interface sincos_horner_if;
  logic        start;
  logic        sel;
  logic [31:0] x;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;

  modport master (
    output start, sel, x,
    input  busy, done, result, err
  );

  modport slave (
    input  start, sel, x,
    output busy, done, result, err
  );
endinterface

// File: rtl/sincos_coef_rom.sv
// Coefficient table indexed by function select and Horner step.
// Index 0 is the highest-order term; the last index is 1.0.
module sincos_coef_rom
  import sincos_pkg::*;
(
  input  logic        i_sel,
  input  logic [2:0]  i_k,
  output logic [31:0] o_coef
);

  always_comb begin
    o_coef = C_ONE;
    if (!i_sel) begin
      case (i_k)
        3'd0:    o_coef = SIN_C7;
        3'd1:    o_coef = SIN_C5;
        3'd2:    o_coef = SIN_C3;
        default: o_coef = C_ONE;
      endcase
    end else begin
      case (i_k)
        3'd0:    o_coef = COS_C8;
        3'd1:    o_coef = COS_C6;
        3'd2:    o_coef = COS_C4;
        3'd3:    o_coef = COS_C2;
        default: o_coef = C_ONE;
      endcase
    end
  end

endmodule

// File: rtl/sincos_horner.sv
// Sequential sin/cos via Horner evaluation in x^2, driving an
// external combinational FP multiplier and adder.
module sincos_horner
  import sincos_pkg::*;
#(
  parameter logic [31:0] EXC_RESULT = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  sincos_horner_if.slave req,
  output logic [31:0]    mul_a,
  output logic [31:0]    mul_b,
  input  logic [31:0]    mul_p,
  output logic [31:0]    add_a,
  output logic [31:0]    add_b,
  input  logic [31:0]    add_s
);

  state_t      r_state;
  logic [31:0] r_x;
  logic        r_sel;
  logic [31:0] r_x2;
  logic [31:0] r_acc;
  logic [31:0] r_t;
  logic [2:0]  r_k;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_result;

  logic [2:0]  w_rom_k;
  logic [31:0] w_coef;
  logic        w_last;

  // ADD consumes the term below the one already folded into acc
  assign w_rom_k = (r_state == ADD) ? (r_k + 3'd1) : 3'd0;
  assign w_last  = r_sel ? (r_k == COS_STEPS - 3'd1)
                         : (r_k == SIN_STEPS - 3'd1);

  sincos_coef_rom u_rom (
    .i_sel  (r_sel),
    .i_k    (w_rom_k),
    .o_coef (w_coef)
  );

  assign req.busy   = r_busy;
  assign req.done   = r_done;
  assign req.err    = r_err;
  assign req.result = r_result;

  always_comb begin
    mul_a = 32'h0;
    mul_b = 32'h0;
    add_a = 32'h0;
    add_b = 32'h0;
    case (r_state)
      SQ: begin
        mul_a = r_x;
        mul_b = r_x;
      end
      MUL: begin
        mul_a = r_acc;
        mul_b = r_x2;
      end
      ADD: begin
        add_a = r_t;
        add_b = w_coef;
      end
      FIN: begin
        mul_a = r_acc;
        mul_b = r_x;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_x      <= 32'h0;
      r_sel    <= 1'b0;
      r_x2     <= 32'h0;
      r_acc    <= 32'h0;
      r_t      <= 32'h0;
      r_k      <= 3'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= 32'h0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req.start) begin
            if (&req.x[30:23]) begin
              r_result <= EXC_RESULT;
              r_err    <= 1'b1;
              r_done   <= 1'b1;
            end else begin
              r_x     <= req.x;
              r_sel   <= req.sel;
              r_err   <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= SQ;
            end
          end
        end
        SQ: begin
          r_x2    <= mul_p;
          r_acc   <= w_coef;
          r_k     <= 3'd0;
          r_state <= MUL;
        end
        MUL: begin
          r_t     <= mul_p;
          r_state <= ADD;
        end
        ADD: begin
          r_acc <= add_s;
          r_k   <= r_k + 3'd1;
          if (!w_last) begin
            r_state <= MUL;
          end else if (r_sel) begin
            r_result <= add_s;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_result <= mul_p;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_horner.sv
// Scoreboard bench for sincos_horner with behavioural FP multiplier
// and adder models attached to the operand ports.
module tb_sincos_horner;

  logic        clk;
  logic        rst_n;
  logic [31:0] mul_a, mul_b, mul_p;
  logic [31:0] add_a, add_b, add_s;

  sincos_horner_if ifc ();

  sincos_horner #(.EXC_RESULT(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (ifc.slave),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p),
    .add_a (add_a),
    .add_b (add_b),
    .add_s (add_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real p;
    real v;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    p = 1.0;
    if (e > 127) repeat (e - 127) p = p * 2.0;
    else         repeat (127 - e) p = p / 2.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * p;
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic s;
    real  a;
    int   e;
    int   mi;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    mi = $rtoi((a - 1.0) * 8388608.0 + 0.5);
    if (mi >= 8388608) begin mi = 0; e++; end
    if (e <= 0) return {s, 31'h0};
    return {s, e[7:0], mi[22:0]};
  endfunction

  always_comb mul_p = r2f(f2r(mul_a) * f2r(mul_b));
  always_comb add_s = r2f(f2r(add_a) + f2r(add_b));

  typedef struct {
    int          kind;
    logic [31:0] exp;
    real         tol;
    logic        err;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // monitor: pops an expectation whenever done is presented
  always @(negedge clk) begin
    if (rst_n && ifc.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h with no request",
                 ifc.result);
      end else begin
        exp_t e;
        int   d;
        real  ar;
        e = sb.pop_front();
        checks++;
        case (e.kind)
          0: begin
            if (ifc.result !== e.exp) begin
              errors++;
              $display("FAIL result: got %h expected %h",
                       ifc.result, e.exp);
            end
          end
          1: begin
            d = int'(ifc.result) - int'(e.exp);
            if (d < 0) d = -d;
            if (ifc.result[31] !== e.exp[31] || d > 4) begin
              errors++;
              $display("FAIL result_ulp: got %h expected %h +-4ulp",
                       ifc.result, e.exp);
            end
          end
          default: begin
            ar = f2r(ifc.result) - f2r(e.exp);
            if (ar < 0.0) ar = -ar;
            if (!(ar < e.tol)) begin
              errors++;
              $display("FAIL result_abs: got %h expected %h within %g",
                       ifc.result, e.exp, e.tol);
            end
          end
        endcase
        chk("err", {31'h0, ifc.err}, {31'h0, e.err});
        chk("latency", cyc - e.issue, e.lat);
      end
    end
  end

  task automatic issue(input logic s, input logic [31:0] x,
                       input int kind, input logic [31:0] ev,
                       input real tol, input logic er, input int lat);
    exp_t e;
    e.kind  = kind;
    e.exp   = ev;
    e.tol   = tol;
    e.err   = er;
    e.lat   = lat;
    e.issue = cyc;
    sb.push_back(e);
    ifc.start = 1'b1;
    ifc.sel   = s;
    ifc.x     = x;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0",
               name, sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_zero_outs(input string name);
    chk({name, "_done"},   {31'h0, ifc.done}, 32'h0);
    chk({name, "_busy"},   {31'h0, ifc.busy}, 32'h0);
    chk({name, "_err"},    {31'h0, ifc.err},  32'h0);
    chk({name, "_result"}, ifc.result, 32'h0);
    chk({name, "_ops"}, mul_a | mul_b | add_a | add_b, 32'h0);
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.sel   = 1'b0;
    ifc.x     = 32'h0;
    repeat (2) @(negedge clk);
    chk_zero_outs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(1'b0, 32'h0000_0000, 0, 32'h0000_0000, 0.0, 1'b0, 9);
    chk("busy_run", {31'h0, ifc.busy}, 32'h1);
    wait_drain("sin0");
    issue(1'b1, 32'h0000_0000, 0, 32'h3F80_0000, 0.0, 1'b0, 10);
    wait_drain("cos0");
    issue(1'b0, 32'h3F00_0000, 1, 32'h3EF5_7744, 0.0, 1'b0, 9);
    wait_drain("sin_half");
    issue(1'b1, 32'h3F00_0000, 1, 32'h3F60_A940, 0.0, 1'b0, 10);
    wait_drain("cos_half");
    issue(1'b0, 32'h3FC9_0FDB, 2, 32'h3F80_0000, 2.0e-4, 1'b0, 9);
    wait_drain("sin_pi2");

    issue(1'b0, 32'h7FC0_0000, 0, 32'h0000_0000, 0.0, 1'b1, 1);
    chk("nan_busy", {31'h0, ifc.busy}, 32'h0);
    wait_drain("nan");

    // second start during a busy op must be dropped
    base = done_cnt;
    issue(1'b0, 32'h3F00_0000, 1, 32'h3EF5_7744, 0.0, 1'b0, 9);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.sel   = 1'b1;
    ifc.x     = 32'h3F80_0000;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_drain("ignored");
    repeat (12) @(negedge clk);
    chk("single_done", done_cnt - base, 1);

    // abort mid-operation
    base = done_cnt;
    ifc.start = 1'b1;
    ifc.sel   = 1'b1;
    ifc.x     = 32'h3F00_0000;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", {31'h0, ifc.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_zero_outs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("no_done_after_abort", done_cnt - base, 0);
    chk("idle_after_abort", {31'h0, ifc.busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
